// File: rtl/data_sram_responder.sv
// Memory-side responder for the CPU data port: word-organised array with
// byte-strobed stores and in-order responses after a fixed latency, with a
// bounded number of accepted-but-unanswered transactions.
module data_sram_responder #(
  parameter int DEPTH_LOG2      = 10,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int         DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [2:0] TIMER_INIT = 3'(LATENCY - 1);
  localparam logic [2:0] MAX_CNT    = 3'(MAX_OUTSTANDING);

  // Response queue, entry 0 is the head (oldest transaction).
  logic [MAX_OUTSTANDING-1:0] valid_q, valid_d;
  logic [MAX_OUTSTANDING-1:0] is_write_q, is_write_d;
  logic [31:0]                data_q  [MAX_OUTSTANDING];
  logic [31:0]                data_d  [MAX_OUTSTANDING];
  logic [2:0]                 timer_q [MAX_OUTSTANDING];
  logic [2:0]                 timer_d [MAX_OUTSTANDING];
  logic [2:0]                 count_q, count_d;

  // Data array; deliberately not reset so contents survive a reset.
  logic [31:0] mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0] index_s;
  logic                  head_fire_s;
  logic                  accept_s;
  logic [2:0]            push_idx_s;
  logic                  unused_addr_s;

  // Timer of a live entry counts down to zero and then holds there.
  function automatic logic [2:0] tick(input logic v, input logic [2:0] t);
    if (v && (t != 3'd0)) begin
      return t - 3'd1;
    end else begin
      return t;
    end
  endfunction

  assign index_s       = addr[DEPTH_LOG2+1:2];
  assign unused_addr_s = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};
  assign head_fire_s   = valid_q[0] & (timer_q[0] == 3'd0);
  assign accept_s      = req & addr_ok;
  // After a pop the queue shifts down one slot, so the new entry lands one lower.
  assign push_idx_s    = count_q - {2'b00, head_fire_s};

  // Handshake outputs: accept when a slot is free or the head retires this cycle.
  always_comb begin
    addr_ok = resetn & ((count_q < MAX_CNT) | head_fire_s);
    data_ok = head_fire_s;
    rdata   = 32'd0;
    if (head_fire_s && !is_write_q[0]) begin
      rdata = data_q[0];
    end else begin
      rdata = 32'd0;
    end
  end

  // Next queue state: push has priority, else shift on pop, else age in place.
  always_comb begin
    count_d = count_q + {2'b00, accept_s} - {2'b00, head_fire_s};
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      int j;
      j = (i < MAX_OUTSTANDING - 1) ? i + 1 : i;
      valid_d[i]    = valid_q[i];
      is_write_d[i] = is_write_q[i];
      data_d[i]     = data_q[i];
      timer_d[i]    = tick(valid_q[i], timer_q[i]);
      if (accept_s && (3'(i) == push_idx_s)) begin
        valid_d[i]    = 1'b1;
        is_write_d[i] = wr;
        data_d[i]     = wr ? 32'd0 : mem_q[index_s];
        timer_d[i]    = TIMER_INIT;
      end else if (head_fire_s && (i < MAX_OUTSTANDING - 1)) begin
        valid_d[i]    = valid_q[j];
        is_write_d[i] = is_write_q[j];
        data_d[i]     = data_q[j];
        timer_d[i]    = tick(valid_q[j], timer_q[j]);
      end else if (head_fire_s) begin
        valid_d[i]    = 1'b0;
        is_write_d[i] = 1'b0;
        data_d[i]     = 32'd0;
        timer_d[i]    = 3'd0;
      end else begin
        timer_d[i]    = tick(valid_q[i], timer_q[i]);
      end
    end
  end

  // Queue state register; reset drops every pending response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q    <= '0;
      is_write_q <= '0;
      count_q    <= 3'd0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        data_q[i]  <= 32'd0;
        timer_q[i] <= 3'd0;
      end
    end else begin
      valid_q    <= valid_d;
      is_write_q <= is_write_d;
      count_q    <= count_d;
      data_q     <= data_d;
      timer_q    <= timer_d;
    end
  end

  // Byte-strobed store into the array on the accept edge.
  always_ff @(posedge clk) begin
    if (accept_s && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem_q[index_s][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
